// File: rtl/mux9_arb_pkg.sv
// Shared constants, state type and index helpers for the 9-way round-robin mux arbiter.
package mux9_arb_pkg;

  localparam int N_REQ = 9;
  localparam int SEL_W = 4;
  localparam logic [SEL_W-1:0] SEL_IDLE = 4'hF;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // Successor index with 8 -> 0 wrap; out-of-range codes restart at 0.
  function automatic logic [SEL_W-1:0] rr_next(input logic [SEL_W-1:0] k);
    return (k >= 4'd8) ? '0 : k + 4'd1;
  endfunction

  function automatic logic [N_REQ-1:0] onehot9(input logic [SEL_W-1:0] k);
    return (k < 4'd9) ? (9'd1 << k) : '0;
  endfunction

endpackage

// File: rtl/mux9_rr_arbiter_pick.sv
// rr_pick9: combinational round-robin search over nine requests starting at 'start'.
module rr_pick9
  import mux9_arb_pkg::*;
(
  input  logic [N_REQ-1:0] ereq,
  input  logic [SEL_W-1:0] start,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  logic [SEL_W-1:0]   start_c;
  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0]   rot;
  logic [SEL_W-1:0]   off;
  logic [SEL_W:0]     sum;

  assign start_c = (start > 4'd8) ? '0 : start;
  assign dbl     = {ereq, ereq};

  // Rotate so that bit 0 of rot is request 'start'.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rot
    assign rot[gi] = dbl[{1'b0, start_c} + 5'(gi)];
  end

  always_comb begin
    found = 1'b0;
    off   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        found = 1'b1;
        off   = 4'(i);
      end
    end
  end

  assign sum = {1'b0, start_c} + {1'b0, off};
  assign idx = (sum >= 5'd9) ? 4'(sum - 5'd9) : 4'(sum);

endmodule

// File: rtl/mux9_rr_arbiter.sv
// Round-robin owner arbiter for the shared 9:1 mux; grant held until done/drop.
// Optional forced release after MAX_HOLD cycles when MUX9_ARB_TIMEOUT_EN is defined.
module mux9_rr_arbiter
  import mux9_arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  input  logic [N_REQ-1:0] mask,
  output logic [N_REQ-1:0] grant,
  output logic [SEL_W-1:0] sel,
  output logic             busy,
  output logic             timeout
);

  arb_state_t       state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [SEL_W-1:0] sel_q, sel_d;

  logic [N_REQ-1:0] ereq;
  logic             owner_req;
  logic             tmo;
  logic             rel;
  logic             new_grant;
  logic [SEL_W-1:0] start;
  logic             found;
  logic [SEL_W-1:0] idx;

  assign ereq      = req & ~mask;
  assign owner_req = |(ereq & grant_q);
  assign rel       = (state_q == GRANT) && (done || !owner_req || tmo);
  // While granted the search starts just past the owner, so it gets lowest priority.
  assign start     = (state_q == GRANT) ? rr_next(sel_q) : ptr_q;

  rr_pick9 u_pick (
    .ereq  (ereq),
    .start (start),
    .found (found),
    .idx   (idx)
  );

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    sel_d     = sel_q;
    new_grant = 1'b0;
    if ((state_q == IDLE) || rel) begin
      if (rel) ptr_d = rr_next(sel_q);
      if (found) begin
        state_d   = GRANT;
        grant_d   = onehot9(idx);
        sel_d     = idx;
        new_grant = 1'b1;
      end else begin
        state_d = IDLE;
        grant_d = '0;
        sel_d   = SEL_IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      sel_q   <= SEL_IDLE;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
    end
  end

`ifdef MUX9_ARB_TIMEOUT_EN
  localparam int CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tmo = (state_q == GRANT) && (cnt_q == CNT_W'(MAX_HOLD - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (new_grant)             cnt_d = '0;
    else if (state_q == GRANT) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`else
  logic unused_hold;
  assign unused_hold = new_grant & (MAX_HOLD > 0);
  assign tmo         = 1'b0;
`endif

  assign grant   = grant_q;
  assign sel     = sel_q;
  assign busy    = (state_q == GRANT);
  assign timeout = tmo;

endmodule

// File: tb/tb_mux9_rr_arbiter.sv
// Vector-table and scoreboard bench for mux9_rr_arbiter (default and timeout builds).
module tb_mux9_rr_arbiter;

  logic       clk;
  logic       reset;
  logic [8:0] req;
  logic       done;
  logic [8:0] mask;
  logic [8:0] grant;
  logic [3:0] sel;
  logic       busy;
  logic       timeout;

  int total;
  int bad;

  typedef struct {
    logic [8:0] req;
    logic [8:0] mask;
    logic       done;
    logic [8:0] g;
    logic [3:0] s;
    logic       b;
  } vec_t;

  typedef struct {
    logic [8:0] g;
    logic [3:0] s;
    logic       b;
    logic       t;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[20];

  mux9_rr_arbiter #(.MAX_HOLD(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .done    (done),
    .mask    (mask),
    .grant   (grant),
    .sel     (sel),
    .busy    (busy),
    .timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input exp_t e);
    chk({tag, ".grant"}, grant, e.g);
    chk({tag, ".sel"}, 9'(sel), 9'(e.s));
    chk({tag, ".busy"}, 9'(busy), 9'(e.b));
    chk({tag, ".timeout"}, 9'(timeout), 9'(e.t));
  endtask

  // One transaction: drive at negedge, queue expectation, compare just after the edge.
  task automatic step(input string tag, input logic [8:0] r, input logic [8:0] m, input logic d,
                      input logic [8:0] g, input logic [3:0] s, input logic b, input logic t);
    exp_t e;
    @(negedge clk);
    req  = r;
    mask = m;
    done = d;
    e.g = g; e.s = s; e.b = b; e.t = t;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check_outs(tag, e);
    $display("%s req=%h mask=%h done=%b -> grant=%h sel=%h busy=%b timeout=%b",
             tag, r, m, d, grant, sel, busy, timeout);
  endtask

  initial begin
    exp_t rst_e;
    total = 0;
    bad   = 0;
    req   = '0;
    mask  = '0;
    done  = 1'b0;
    reset = 1'b1;

    vecs[0]  = '{9'h000, 9'h000, 1'b0, 9'h000, 4'hF, 1'b0};
    vecs[1]  = '{9'h000, 9'h000, 1'b0, 9'h000, 4'hF, 1'b0};
    vecs[2]  = '{9'h000, 9'h000, 1'b0, 9'h000, 4'hF, 1'b0};
    vecs[3]  = '{9'h000, 9'h000, 1'b0, 9'h000, 4'hF, 1'b0};
    vecs[4]  = '{9'h000, 9'h000, 1'b0, 9'h000, 4'hF, 1'b0};
    vecs[5]  = '{9'h011, 9'h000, 1'b0, 9'h001, 4'h0, 1'b1};
    vecs[6]  = '{9'h011, 9'h000, 1'b1, 9'h010, 4'h4, 1'b1};
    vecs[7]  = '{9'h011, 9'h000, 1'b0, 9'h010, 4'h4, 1'b1};
    vecs[8]  = '{9'h000, 9'h000, 1'b0, 9'h000, 4'hF, 1'b0};
    vecs[9]  = '{9'h100, 9'h000, 1'b0, 9'h100, 4'h8, 1'b1};
    vecs[10] = '{9'h101, 9'h000, 1'b1, 9'h001, 4'h0, 1'b1};
    vecs[11] = '{9'h001, 9'h000, 1'b1, 9'h001, 4'h0, 1'b1};
    vecs[12] = '{9'h001, 9'h000, 1'b0, 9'h001, 4'h0, 1'b1};
    vecs[13] = '{9'h008, 9'h000, 1'b0, 9'h008, 4'h3, 1'b1};
    vecs[14] = '{9'h028, 9'h008, 1'b0, 9'h020, 4'h5, 1'b1};
    vecs[15] = '{9'h028, 9'h008, 1'b0, 9'h020, 4'h5, 1'b1};
    vecs[16] = '{9'h1FF, 9'h000, 1'b0, 9'h020, 4'h5, 1'b1};
    vecs[17] = '{9'h1FF, 9'h000, 1'b1, 9'h040, 4'h6, 1'b1};
    vecs[18] = '{9'h1FF, 9'h1FF, 1'b0, 9'h000, 4'hF, 1'b0};
    vecs[19] = '{9'h1FF, 9'h1FF, 1'b0, 9'h000, 4'hF, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    rst_e = '{9'h000, 4'hF, 1'b0, 1'b0};
    check_outs("reset", rst_e);
    $display("reset grant=%h sel=%h busy=%b timeout=%b", grant, sel, busy, timeout);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 20; i++) begin
      step($sformatf("vec%0d", i), vecs[i].req, vecs[i].mask, vecs[i].done,
           vecs[i].g, vecs[i].s, vecs[i].b, 1'b0);
    end

    // Pointer sits at 7 after owner 6 was released: search 7,8,0,1 finds 1.
    step("midgrant", 9'h002, 9'h000, 1'b0, 9'h002, 4'h1, 1'b1, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check_outs("async_rst", rst_e);
    $display("async_rst grant=%h sel=%h busy=%b", grant, sel, busy);
    @(negedge clk);
    req   = '0;
    reset = 1'b0;

    step("hold0", 9'h006, 9'h000, 1'b0, 9'h002, 4'h1, 1'b1, 1'b0);
`ifdef MUX9_ARB_TIMEOUT_EN
    step("hold1", 9'h006, 9'h000, 1'b0, 9'h002, 4'h1, 1'b1, 1'b0);
    step("hold2", 9'h006, 9'h000, 1'b0, 9'h002, 4'h1, 1'b1, 1'b0);
    step("hold3", 9'h006, 9'h000, 1'b0, 9'h002, 4'h1, 1'b1, 1'b1);
    step("hold4", 9'h006, 9'h000, 1'b0, 9'h004, 4'h2, 1'b1, 1'b0);
`else
    for (int i = 1; i <= 22; i++) begin
      step($sformatf("hold%0d", i), 9'h006, 9'h000, 1'b0, 9'h002, 4'h1, 1'b1, 1'b0);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
